// File: rtl/wind_pkg.sv
// Geometry shared by the wind-box drawing stages: the box, its border, and
// the centred wind-bar placement.
package wind_pkg;

  localparam logic [10:0] BIG_RECT_X      = 11'd448;
  localparam logic [10:0] BIG_RECT_Y      = 11'd40;
  localparam logic [10:0] BIG_RECT_WIDTH  = 11'd128;
  localparam logic [10:0] BIG_RECT_HEIGHT = 11'd16;
  localparam logic [10:0] BIG_RECT_X_MAX  = BIG_RECT_X + BIG_RECT_WIDTH;
  localparam logic [10:0] BIG_RECT_Y_MAX  = BIG_RECT_Y + BIG_RECT_HEIGHT;

  localparam logic [10:0] BORDER_THICKNESS = 11'd2;
  localparam logic [11:0] BORDER_COLOR     = 12'hFFF;

  // Bar geometry: centre column, vertical inset of the bar, largest magnitude.
  localparam logic [10:0]        CX         = BIG_RECT_X + BIG_RECT_WIDTH / 2;
  localparam logic [10:0]        BAR_MARGIN = 11'd3;
  localparam logic signed [7:0]  WIND_MAX   = 8'sd56;

  function automatic logic signed [7:0] clamp_wind(input logic signed [6:0] w);
    logic signed [7:0] wx;
    wx = {w[6], w};
    if (wx > WIND_MAX)       return WIND_MAX;
    else if (wx < -WIND_MAX) return -WIND_MAX;
    else                     return wx;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle passed between drawing stages.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/wind_level_ctrl.sv
// Wind target capture and per-frame stepping of the displayed bar level.
module wind_level_ctrl
  import wind_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [6:0] wind_in,
  input  logic              wind_valid,
  input  logic              vblnk,
  output logic signed [7:0] level,
  output logic              wind_settled
);

  localparam logic signed [8:0] STEP_D = 9'(STEP);
  localparam logic signed [7:0] STEP_L = 8'(STEP);

  logic signed [7:0] target;
  logic              vblnk_d;
  logic              frame_tick;
  logic signed [8:0] diff;
  logic signed [7:0] level_nxt;

  // Step always uses the registered target, so a same-cycle wind_valid
  // only affects the next tick.
  always_comb begin
    frame_tick = vblnk & ~vblnk_d;
    diff       = {target[7], target} - {level[7], level};
    level_nxt  = target;
    if (diff > STEP_D)       level_nxt = level + STEP_L;
    else if (diff < -STEP_D) level_nxt = level - STEP_L;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      target  <= '0;
      level   <= '0;
      vblnk_d <= 1'b0;
    end else begin
      vblnk_d <= vblnk;
      if (wind_valid) target <= clamp_wind(wind_in);
      if (frame_tick) level  <= level_nxt;
    end
  end

  assign wind_settled = (level == target);

endmodule

// File: rtl/draw_wind_indicator.sv
// Overlays the wind-strength bar and centre marker on the wind box, with a
// fixed two-cycle pipeline on every vga field.
module draw_wind_indicator
  import wind_pkg::*;
#(
  parameter int          STEP         = 1,
  parameter logic [11:0] BAR_COLOR    = 12'h48F,
  parameter logic [11:0] MARKER_COLOR = 12'h000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [6:0] wind_in,
  input  logic              wind_valid,
  vga_if.vga_in             vga_in,
  vga_if.vga_out            vga_out,
  output logic              wind_settled
);

  logic signed [7:0] level;

  wind_level_ctrl #(.STEP(STEP)) u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .wind_in      (wind_in),
    .wind_valid   (wind_valid),
    .vblnk        (vga_in.vblnk),
    .level        (level),
    .wind_settled (wind_settled)
  );

  logic [10:0] h1, v1;
  logic        hs1, vs1, hb1, vb1;
  logic [11:0] rgb1;

  always_ff @(posedge clk) begin
    if (rst) begin
      h1   <= '0;
      v1   <= '0;
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      hb1  <= 1'b0;
      vb1  <= 1'b0;
      rgb1 <= '0;
    end else begin
      h1   <= vga_in.hcount;
      v1   <= vga_in.vcount;
      hs1  <= vga_in.hsync;
      vs1  <= vga_in.vsync;
      hb1  <= vga_in.hblnk;
      vb1  <= vga_in.vblnk;
      rgb1 <= vga_in.rgb;
    end
  end

  logic [11:0] cx_w, h1_w, bar_edge;
  logic        box_rows, bar_rows, marker, bar;
  logic [11:0] rgb_nxt;

  // bar_edge is CX+level; always positive since |level| <= WIND_MAX < CX.
  always_comb begin
    cx_w     = {1'b0, CX};
    h1_w     = {1'b0, h1};
    bar_edge = cx_w + {{4{level[7]}}, level};
    box_rows = (v1 >= BIG_RECT_Y) && (v1 < BIG_RECT_Y_MAX);
    bar_rows = (v1 >= BIG_RECT_Y + BAR_MARGIN) && (v1 < BIG_RECT_Y_MAX - BAR_MARGIN);
    marker   = ((h1 == CX - 11'd1) || (h1 == CX)) && box_rows;
    bar      = 1'b0;
    if (level > 8'sd0)      bar = bar_rows && (h1_w >= cx_w) && (h1_w < bar_edge);
    else if (level < 8'sd0) bar = bar_rows && (h1_w >= bar_edge) && (h1_w < cx_w);

    rgb_nxt = rgb1;
    if (hb1 || vb1)  rgb_nxt = 12'h000;
    else if (marker) rgb_nxt = MARKER_COLOR;
    else if (bar)    rgb_nxt = BAR_COLOR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= h1;
      vga_out.vcount <= v1;
      vga_out.hsync  <= hs1;
      vga_out.vsync  <= vs1;
      vga_out.hblnk  <= hb1;
      vga_out.vblnk  <= vb1;
      vga_out.rgb    <= rgb_nxt;
    end
  end

endmodule

// File: doc/draw_wind_indicator.md
# draw_wind_indicator

Draws the live wind-strength bar inside the wind box that draw_wind_background paints at the top of the screen, and is the stage directly downstream of it in the vga_if chain. A signed wind value from game logic sets a target level. The displayed bar moves toward that target by a fixed number of pixels per frame, updating only at frame boundaries, so the bar animates smoothly. The pixel stream passes through with a fixed 2-cycle latency on every vga_if field.

## Interface
- STEP, 1: pixels the displayed level moves toward the target per frame (1..WIND_MAX).
- BAR_COLOR, 12'h48F: bar fill colour.
- MARKER_COLOR, 12'h000: centre zero-marker colour.
- clk  in  1  pixel clock.
- rst  in  1  reset; one clock, synchronous and active-high.
- wind_in  in  7  signed wind value, in pixels (two's complement).
- wind_valid  in  1  single-cycle strobe; wind_in is captured as the new target.
- vga_in  vga_if.vga_in  —  timing and rgb from draw_wind_background.
- vga_out  vga_if.vga_out  —  timing and rgb with the indicator overlaid.
- wind_settled  out  1  high when displayed level == target.

## Operation
- Geometry (shared constants):
  - Box: x in [BIG_RECT_X, BIG_RECT_X_MAX), y in [BIG_RECT_Y, BIG_RECT_Y_MAX).
  - CX = BIG_RECT_X + BIG_RECT_WIDTH/2, which is 512 at 1024 px width.
  - WIND_MAX = 56.
  - Bar rows: y in [BIG_RECT_Y+3, BIG_RECT_Y_MAX-3).
- Target capture:
  - On wind_valid, target <= clamp(wind_in, -WIND_MAX, +WIND_MAX). Example: -64 gives -56; +60 gives +56.
  - Without wind_valid, target holds its value.
- Frame tick: one cycle when vga_in.vblnk rises (0 in the previous cycle, 1 now).
- Level update, on frame tick only:
  - If |target - level| <= STEP: level <= target.
  - Otherwise level moves by ±STEP toward target.
  - The level never overshoots the target. Crossing zero is allowed.
- Level width: level and target are 8-bit signed; the difference is computed at 9 bits, so no overflow is possible.
- wind_settled is combinational from the level and target registers: (level == target).
- Pixel classification, on pipeline stage-1 values:
  - marker: hcount in {CX-1, CX} and vcount inside the box rows.
  - bar, level > 0: hcount in [CX, CX+level) and vcount in the bar rows.
  - bar, level < 0: hcount in [CX+level, CX) and vcount in the bar rows.
  - level == 0: no bar.
- Colour priority, highest first:
  - blanking (hblnk | vblnk): rgb = 0.
  - marker: MARKER_COLOR.
  - bar: BAR_COLOR.
  - otherwise: vga_in.rgb passes through.
- The level used for drawing changes only during vblank, so a frame never tears.
- Simultaneous wind_valid and frame tick: the step uses the old target; the new target is captured in the same cycle and used from the next tick onward.

## Timing
- Reset values:
  - All vga_out fields: 0.
  - target = 0, level = 0.
  - Pipeline registers: 0.
  - wind_settled = 1.
- Latency is 2 cycles for hcount, vcount, hsync, vsync, hblnk, vblnk and rgb; all fields stay mutually aligned.
  - Stage 1: register the inputs and compute the region flags.
  - Stage 2: select the colour and register vga_out.
- Target update: wind_valid at cycle N makes target visible at N+1.
- Level update: the level changes one cycle after the frame-tick cycle.
- Reset mid-frame: the outputs are 0 for the reset cycle. After reset the level restarts from 0; no stale bar is drawn.
- Convergence: after a target change, wind_settled goes high after ceil(|Δ|/STEP) frame ticks.

## Structure
- Move BIG_RECT_* and the border constants out of draw_wind_background into a new wind_pkg, so both drawing stages share the geometry.
- wind_pkg also holds WIND_MAX, CX and the bar margin (3).
- One sub-module: wind_level_ctrl.
  - Contents: target capture, clamp, frame-tick detection, level stepping, wind_settled.
  - Output: signed level [7:0].
- The top level does the pixel pipeline and instantiates wind_level_ctrl once.

## Test plan
- Reset, then free-running 1024x768 timing, no wind_valid:
  - Inside the box, only the marker columns 511/512 are 12'h000 and all other box pixels pass through.
  - wind_settled = 1.
- wind_in = +20 with STEP = 1:
  - level reaches 20 after exactly 20 frames.
  - Frame 21 shows x 512..531 in BAR_COLOR on rows 43..52, with the marker still drawn over x=512.
- wind_in = -64:
  - Clamps to -56; the final bar spans x 456..511.
  - x=511 shows the marker colour.
- Level at +10, then wind_in = -10 with STEP = 4:
  - Per-frame levels are 6, 2, -2, -6, -10.
  - wind_settled rises after the 5th tick.
- wind_valid asserted in the same cycle as the vblnk rising edge:
  - The step goes toward the old target; the new target governs the following frame.
- Assert rst in mid-frame with level = 30:
  - vga_out is 0 for the reset cycle and level becomes 0.
  - Every output field lags the matching vga_in field by exactly 2 cycles, checked throughout.
